// File: rtl/mem_io_ctrl_if.sv
// mem_io_ctrl_if: request, data-memory and IO bus bundle; slave = controller, master = requester/environment
interface mem_io_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int IO_CH = 4
);
  logic req_i;
  logic we_i;
  logic [1:0] size_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0] wdata_i;
  logic confirm_i;
  logic [16*IO_CH-1:0] io_rdata_i;
  logic [ADDR_W-1:0] m_addr_o;
  logic m_we_o;
  logic [3:0] m_be_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;
  logic io_we_o;
  logic [31:0] io_wdata_o;
  logic [ADDR_W-1:0] io_addr_o;
  logic busy_o;
  logic done_o;
  logic err_o;
  logic [31:0] rdata_o;
  modport master (
    output req_i, we_i, size_i, addr_i, wdata_i, confirm_i, io_rdata_i, m_rdata_i,
    input m_addr_o, m_we_o, m_be_o, m_wdata_o, io_we_o, io_wdata_o, io_addr_o, busy_o, done_o, err_o, rdata_o
  );
  modport slave (
    input req_i, we_i, size_i, addr_i, wdata_i, confirm_i, io_rdata_i, m_rdata_i,
    output m_addr_o, m_we_o, m_be_o, m_wdata_o, io_we_o, io_wdata_o, io_addr_o, busy_o, done_o, err_o, rdata_o
  );
endinterface

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: load/store controller splitting requests between data memory and IO channels, with confirm-button flag
module mem_io_ctrl #(
  parameter int ADDR_W = 14,
  parameter int IO_CH = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = 14'h3C00,
  parameter logic [ADDR_W-1:0] CONFIRM_ADDR = 14'h3C80,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  mem_io_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM_WAIT, IO_ACC, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q, idx;
  logic [1:0] size_q, cnt;
  logic [31:0] wdata_q, rdata, lane, mem_val, io_val;
  logic [15:0] ch;
  logic we_q, io_q, err_q, conf_d, conf_flag, misalign, accept, cap_mem, cap_io, clr;
  assign misalign = (bus.size_i == 2'b01 && bus.addr_i[1:0] != 2'b00) || (bus.size_i == 2'b11 && bus.addr_i[0]);
  assign accept = state == IDLE && bus.req_i;
  assign cap_mem = state == MEM_WAIT && cnt == 2'(MEM_LAT - 1);
  assign cap_io = state == IO_ACC && !we_q;
  assign clr = cap_io && addr_q == CONFIRM_ADDR;
  assign lane = bus.m_rdata_i >> {addr_q[1:0], 3'b000};
  assign mem_val = size_q == 2'b01 ? lane
                 : size_q == 2'b10 ? {24'b0, lane[7:0]}
                 : size_q == 2'b11 ? {{16{lane[15]}}, lane[15:0]}
                 : {{24{lane[7]}}, lane[7:0]};
  assign idx = (addr_q - IO_BASE) >> 4;
  assign ch = 16'(bus.io_rdata_i >> {idx[2:0], 4'b0000});
  assign io_val = addr_q == CONFIRM_ADDR ? {31'b0, conf_flag}
                : idx < ADDR_W'(IO_CH) ? {{16{ch[15]}}, ch}
                : 32'b0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (!bus.req_i ? IDLE : misalign ? DONE : (bus.we_i || bus.addr_i >= IO_BASE) ? IO_ACC : MEM_WAIT)
            : state == MEM_WAIT ? (cap_mem ? DONE : MEM_WAIT)
            : state == IO_ACC ? DONE
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      size_q <= 2'b00;
      wdata_q <= 32'b0;
      we_q <= 1'b0;
      io_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= 2'd0;
      rdata <= 32'b0;
      conf_d <= 1'b0;
      conf_flag <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == MEM_WAIT ? cnt + 2'd1 : 2'd0;
      conf_d <= bus.confirm_i;
      conf_flag <= (bus.confirm_i & ~conf_d) | (conf_flag & ~clr);
      rdata <= cap_mem ? mem_val : cap_io ? io_val : rdata;
      if (accept) begin
        addr_q <= bus.addr_i;
        size_q <= bus.size_i;
        wdata_q <= bus.wdata_i;
        we_q <= bus.we_i;
        io_q <= bus.addr_i >= IO_BASE;
        err_q <= misalign;
      end
    end
  end
  assign bus.busy_o = state != IDLE;
  assign bus.done_o = state == DONE;
  assign bus.err_o = state == DONE && err_q;
  assign bus.rdata_o = rdata;
  assign bus.m_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.m_we_o = state == IO_ACC && we_q && !io_q;
  assign bus.m_be_o = !bus.m_we_o ? 4'b0000
                    : size_q == 2'b01 ? 4'b1111
                    : size_q == 2'b11 ? 4'b0011 << addr_q[1:0]
                    : 4'b0001 << addr_q[1:0];
  assign bus.m_wdata_o = !bus.m_we_o ? 32'b0
                       : size_q == 2'b01 ? wdata_q
                       : size_q == 2'b11 ? {2{wdata_q[15:0]}}
                       : {4{wdata_q[7:0]}};
  assign bus.io_we_o = state == IO_ACC && we_q && io_q;
  assign bus.io_wdata_o = bus.io_we_o ? wdata_q : 32'b0;
  assign bus.io_addr_o = addr_q;
endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14: byte address width.
REQ-002 Parameter IO_CH, default 4: number of 16-bit input IO channels; legal range 1..8.
REQ-003 Parameter IO_BASE, default 14'h3C00: first IO address. Addresses >= IO_BASE are IO; all others are memory.
REQ-004 Parameter CONFIRM_ADDR, default 14'h3C80: address of the confirm status register.
REQ-005 Parameter MEM_LAT, default 1: data-memory read latency in cycles; legal range 1..4.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: the only clock; all logic is on its rising edge.
- rst_n, in, 1: synchronous, active-high reset.
- req_i, in, 1: access request; sampled only in IDLE.
- we_i, in, 1: 1 = store, 0 = load.
- size_i, in, 2: 00 = signed byte; 01 = word; 10 = unsigned byte; 11 = signed halfword.
- addr_i, in, ADDR_W: byte address.
- wdata_i, in, 32: store data from the register file.
- confirm_i, in, 1: confirm button level, already debounced.
- io_rdata_i, in, 16*IO_CH: packed input channels; channel k occupies bits [16k+15:16k].
- m_addr_o, out, ADDR_W: word-aligned memory address.
- m_we_o, out, 1: memory write strobe.
- m_be_o, out, 4: memory byte enables.
- m_wdata_o, out, 32: memory write data.
- m_rdata_i, in, 32: memory read data.
- io_we_o, out, 1: IO write strobe.
- io_wdata_o, out, 32: IO write data.
- io_addr_o, out, ADDR_W: IO address.
- busy_o, out, 1: a request is in progress.
- done_o, out, 1: one-cycle completion pulse.
- err_o, out, 1: one-cycle misalignment pulse.
- rdata_o, out, 32: load result, held until the next done_o.

Function
REQ-007 FSM states: IDLE, MEM_WAIT, IO_ACC, DONE; busy_o = 1 in every state except IDLE.
REQ-008 IDLE with req_i=1: the block registers addr_i, we_i, size_i and wdata_i, then checks alignment.
- A word access needs addr[1:0] = 0; a halfword access needs addr[0] = 0.
- Misaligned: go to DONE, pulse err_o together with done_o, assert no strobe, leave rdata_o unchanged.
REQ-009 Aligned memory load: go to MEM_WAIT and hold m_addr_o = {addr[ADDR_W-1:2], 2'b00}; after exactly MEM_LAT cycles capture m_rdata_i and go to DONE.
REQ-010 Aligned memory store: assert m_we_o for exactly one cycle in the cycle after acceptance (state IO_ACC), then go to DONE.
REQ-011 Store byte enables and data:
- Byte: m_be_o = 1 << addr[1:0], wdata[7:0] replicated into all four lanes.
- Halfword: m_be_o = 4'b0011 << addr[1:0], wdata[15:0] replicated into both halves.
- Word: m_be_o = 4'hF, m_wdata_o = wdata.
REQ-012 Load extraction: select the byte/halfword lane at addr[1:0]; sign-extend for sizes 00 and 11, zero-extend for size 10; words pass through unchanged.
REQ-013 IO load: a single cycle in IO_ACC, then DONE.
- Channel index = (addr - IO_BASE) >> 4.
- Index < IO_CH: rdata_o = that 16-bit channel, sign-extended to 32 bits (size is ignored).
- Index >= IO_CH: rdata_o = 0.
REQ-014 A load from CONFIRM_ADDR returns {31'b0, confirm_flag} and clears confirm_flag in the same edge that captures the value.
REQ-015 confirm_flag sets on a rising edge of confirm_i (a 1-cycle-delayed copy is held for edge detection). A set and a clear in the same cycle result in set (the new event is not lost).
REQ-016 IO store: assert io_we_o for one cycle in IO_ACC, with io_wdata_o = wdata and io_addr_o = addr; then DONE.
REQ-017 DONE lasts one cycle: pulse done_o, return to IDLE. A new req_i is accepted at the earliest in the cycle after DONE.
REQ-018 m_we_o, io_we_o, done_o and err_o are 0 in every state other than the one stated above.
REQ-019 m_wdata_o and io_wdata_o are 0 whenever their strobe is 0.
REQ-020 Load latency from the req_i edge to done_o:
- Memory: MEM_LAT + 1 cycles.
- IO: 2 cycles.
- Store: 2 cycles.

Reset
REQ-021 rst_n=1 at a clock edge forces:
- state IDLE;
- confirm_flag, the confirm_i delayed copy, rdata_o and all strobes/pulses to 0;
- m_addr_o, io_addr_o, m_be_o and both wdata outputs to 0.
REQ-022 A reset asserted during MEM_WAIT or IO_ACC abandons the access: no done_o, rdata_o = 0, and no strobe in the following cycle.

Verification
REQ-023 MEM_LAT=2; memory holds word 0x80FF7F01 at address 0x10.
- Load signed byte at 0x11 -> done_o 3 cycles after req_i, rdata_o = 0x0000007F.
- Unsigned byte at 0x13 -> 0x00000080.
- Signed halfword at 0x12 -> 0xFFFF80FF.
REQ-024 Store byte, wdata = 0x000000AB, addr 0x06 -> a single m_we_o cycle with m_addr_o = 0x04, m_be_o = 4'b0100, m_wdata_o = 0xABABABAB.
REQ-025 IO_CH=4; channel 2 = 0x8001; load addr 0x3C20 -> rdata_o = 0xFFFF8001. Load addr 0x3C40 -> rdata_o = 0.
REQ-026 Pulse confirm_i; load 0x3C80 -> 1; load 0x3C80 again -> 0. Pulse confirm_i in the same cycle as the clearing read -> the next read returns 1.
REQ-027 Word load at 0x0A -> err_o and done_o in the same cycle, no m_we_o/io_we_o, rdata_o unchanged.
REQ-028 Reset asserted in MEM_WAIT -> busy_o = 0 and no done_o in the next cycle; a following legal request completes normally.
